// File: rtl/avst_fifo_pkg.sv
// Shared definitions for the Avalon-ST single-clock FIFO family.
//   SYMBOL_W         : bits per Avalon-ST symbol (one byte)
//   avst_pkt_flags_t : start/end-of-packet flags stored alongside a beat
//   empty_w()        : width of the 'empty' sideband for a given payload width
package avst_fifo_pkg;

  localparam int SYMBOL_W = 8;

  typedef struct packed {
    logic sop;
    logic eop;
  } avst_pkt_flags_t;

  // ceil(log2(symbols per beat)), never less than 1 so a single-symbol
  // stream still has a legal (constant-zero) empty field.
  function automatic int empty_w(int data_w);
    int symbols;
    int w;
    symbols = data_w / SYMBOL_W;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < symbols) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/avst_fifo_mem.sv
// Storage array for avst_sc_fifo.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read, gives show-ahead output)
//   rdata : read data
// The array carries no reset; only the pointers in the parent are cleared.
module avst_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int W      = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/avst_sc_fifo.sv
// Single-clock Avalon-ST show-ahead FIFO, ready latency 0 on both ports.
//   clk, areset         : clock, asynchronous active-high reset
//   flush               : synchronous clear of all contents
//   in_valid/ready/data : sink port
//   out_valid/ready/data: source port (out_data = head entry while out_valid)
//   level               : entries held, 0..DEPTH
//   almost_full/empty   : level >= AFULL_THRESH / level <= AEMPTY_THRESH
// Build option AVST_FIFO_PKT_EN adds sop/eop/empty sideband on both ports,
// stored with each beat and carried through unchecked.
module avst_sc_fifo
  import avst_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  localparam int ADDR_W       = $clog2(DEPTH),
  localparam int LVL_W        = $clog2(DEPTH) + 1
`ifdef AVST_FIFO_PKT_EN
  , localparam int EMPTY_W    = empty_w(DATA_WIDTH)
`endif
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef AVST_FIFO_PKT_EN
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [EMPTY_W-1:0]    in_empty,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [EMPTY_W-1:0]    out_empty,
`endif
  output logic [LVL_W-1:0]      level,
  output logic                  almost_full,
  output logic                  almost_empty
);

`ifdef AVST_FIFO_PKT_EN
  localparam int STORE_W = DATA_WIDTH + $bits(avst_pkt_flags_t) + EMPTY_W;
`else
  localparam int STORE_W = DATA_WIDTH;
`endif

  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               push;
  logic               pop;
  logic [STORE_W-1:0] wdata;
  logic [STORE_W-1:0] rdata;

  // Full/empty come only from level; pointers alone are ambiguous when equal.
  assign in_ready     = (level != LVL_W'(DEPTH));
  assign out_valid    = (level != '0);
  assign almost_full  = (level >= LVL_W'(AFULL_THRESH));
  assign almost_empty = (level <= LVL_W'(AEMPTY_THRESH));

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

`ifdef AVST_FIFO_PKT_EN
  avst_pkt_flags_t in_flags;
  avst_pkt_flags_t out_flags;

  assign in_flags.sop = in_sop;
  assign in_flags.eop = in_eop;
  assign wdata        = {in_flags, in_empty, in_data};
  assign {out_flags, out_empty, out_data} = rdata;
  assign out_sop      = out_flags.sop;
  assign out_eop      = out_flags.eop;
`else
  assign wdata    = in_data;
  assign out_data = rdata;
`endif

  // Control state: pointers and level. Flush takes priority over push/pop,
  // so a beat offered in the flush cycle is neither stored nor counted.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_ONE;
      if (pop)  rd_ptr <= rd_ptr + ADDR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
    end
  end

  avst_fifo_mem #(
    .DEPTH  (DEPTH),
    .W      (STORE_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_avst_sc_fifo.sv
// Directed bench for avst_sc_fifo (DATA_WIDTH=32, DEPTH=16, AFULL=12, AEMPTY=2).
module tb_avst_sc_fifo;

  logic        clk;
  logic        areset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  level;
  logic        almost_full;
  logic        almost_empty;
`ifdef AVST_FIFO_PKT_EN
  logic        in_sop, in_eop, out_sop, out_eop;
  logic [1:0]  in_empty, out_empty;
`endif

  int checks = 0;
  int errors = 0;

  avst_sc_fifo #(
    .DATA_WIDTH    (32),
    .DEPTH         (16),
    .AFULL_THRESH  (12),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef AVST_FIFO_PKT_EN
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_empty     (in_empty),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_empty    (out_empty),
`endif
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle();
    in_data = '0;
`ifdef AVST_FIFO_PKT_EN
    in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
`endif
    tick();
    tick();
    checks++;
    if (level !== 5'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset: level=%0d in_ready=%b out_valid=%b ae=%b af=%b, want 0 1 0 1 0",
               level, in_ready, out_valid, almost_empty, almost_full);
    end
    @(negedge clk);
    areset = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      tick();
      checks++;
      if (level !== i[4:0] || almost_full !== (i >= 12) || in_ready !== (i != 16)) begin
        errors++;
        $display("FAIL fill[%0d]: level=%0d af=%b in_ready=%b, want %0d %b %b",
                 i, level, almost_full, in_ready, i, (i >= 12), (i != 16));
      end
    end
    in_data = 32'h11;
    tick();
    checks++;
    if (level !== 5'd16 || in_ready !== 1'b0 || out_data !== 32'h1) begin
      errors++;
      $display("FAIL fill_17th: level=%0d in_ready=%b head=%h, want 16 0 1",
               level, in_ready, out_data);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== i[31:0]) begin
        errors++;
        $display("FAIL drain_data[%0d]: valid=%b data=%h, want 1 %h", i, out_valid, out_data, i);
      end
      tick();
      checks++;
      if (level !== 5'(16 - i) || almost_empty !== ((16 - i) <= 2)) begin
        errors++;
        $display("FAIL drain_level[%0d]: level=%0d ae=%b, want %0d %b",
                 i, level, almost_empty, 16 - i, ((16 - i) <= 2));
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: out_valid=%b, want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 + k;
      checks++;
      if (k == 0) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first: out_valid=%b, want 0", out_valid);
        end
      end else if (out_valid !== 1'b1 || out_data !== 32'(32'h1000 + k - 1)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b data=%h, want 1 %h", k, out_valid, out_data, 32'h1000 + k - 1);
      end
      tick();
      checks++;
      if (level !== 5'd1) begin
        errors++;
        $display("FAIL b2b_level[%0d]: level=%0d, want 1", k, level);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1063) begin
      errors++;
      $display("FAIL b2b_last: valid=%b data=%h, want 1 1063", out_valid, out_data);
    end
    tick();
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: level=%0d valid=%b, want 0 0", level, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h200 + i;
      tick();
    end
    in_data   = 32'h2FF;
    out_ready = 1'b1;
    checks++;
    if (level !== 5'd16 || in_ready !== 1'b0 || out_data !== 32'h200) begin
      errors++;
      $display("FAIL fullpop_pre: level=%0d in_ready=%b head=%h, want 16 0 200", level, in_ready, out_data);
    end
    tick();
    checks++;
    if (level !== 5'd15 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_refused: level=%0d in_ready=%b, want 15 1", level, in_ready);
    end
    out_ready = 1'b0;
    tick();
    checks++;
    if (level !== 5'd16) begin
      errors++;
      $display("FAIL fullpop_accept: level=%0d, want 16", level);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (out_data !== ((i == 16) ? 32'h2FF : 32'(32'h200 + i))) begin
        errors++;
        $display("FAIL fullpop_order[%0d]: data=%h, want %h", i, out_data,
                 (i == 16) ? 32'h2FF : 32'(32'h200 + i));
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 32'h300 + i;
      tick();
    end
    checks++;
    if (level !== 5'd7) begin
      errors++;
      $display("FAIL flush_pre: level=%0d, want 7", level);
    end
    flush   = 1'b1;
    in_data = 32'hDEAD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush: level=%0d valid=%b ae=%b, want 0 0 1", level, out_valid, almost_empty);
    end
    in_valid = 1'b1;
    in_data  = 32'h3AA;
    tick();
    in_valid = 1'b0;
    checks++;
    if (level !== 5'd1 || out_valid !== 1'b1 || out_data !== 32'h3AA) begin
      errors++;
      $display("FAIL flush_after: level=%0d valid=%b data=%h, want 1 1 3aa", level, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: level=%0d valid=%b, want 0 0", level, out_valid);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h400 + i;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL areset_pre: level=%0d, want 5", level);
    end
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 5'd0) begin
      errors++;
      $display("FAIL areset_async: valid=%b in_ready=%b level=%0d, want 0 1 0", out_valid, in_ready, level);
    end
    @(negedge clk);
    areset = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hA5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5 || level !== 5'd1) begin
      errors++;
      $display("FAIL areset_first: valid=%b data=%h level=%0d, want 1 a5 1", out_valid, out_data, level);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef AVST_FIFO_PKT_EN
  task automatic test_packet();
    logic [35:0] beats [3];
    beats[0] = {1'b1, 1'b0, 2'd0, 32'hB0};
    beats[1] = {1'b0, 1'b0, 2'd0, 32'hB1};
    beats[2] = {1'b0, 1'b1, 2'd3, 32'hB2};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {in_sop, in_eop, in_empty, in_data} = beats[i];
      tick();
    end
    in_valid = 1'b0;
    in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_sop, out_eop, out_empty, out_data} !== beats[i]) begin
        errors++;
        $display("FAIL pkt[%0d]: got %h, want %h", i, {out_sop, out_eop, out_empty, out_data}, beats[i]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_async_reset();
`ifdef AVST_FIFO_PKT_EN
    test_packet();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
